// File: rtl/bp_update_scheduler.sv
// bp_update_scheduler: owns the write port of the 2-bit branch predictor table.
//   After reset or in_pred_clear it sweeps every entry to CNT_INIT, then applies
//   queued ROB commit updates as one read-modify-write per cycle.
// Ports:
//   clk, rst (sync, active-low), rdy (global enable), in_pred_clear (restart sweep)
//   in_rob_bp_res/in_rob_tag/in_rob_jump_res : commit push; out_rob_full : FIFO full
//   out_tbl_ridx/in_tbl_rdata                : combinational table read of FIFO head
//   out_tbl_we/out_tbl_widx/out_tbl_wdata    : registered table write
//   out_pred_ready                           : 0 while the sweep is in progress
// Optional: define BP_STATS_EN to add out_stat_taken/out_stat_nottaken counters.
module bp_update_scheduler #(
  parameter int unsigned TAG_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [1:0]  CNT_INIT   = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             in_pred_clear,
  input  logic             in_rob_bp_res,
  input  logic [TAG_W-1:0] in_rob_tag,
  input  logic             in_rob_jump_res,
  output logic             out_rob_full,
  output logic [TAG_W-1:0] out_tbl_ridx,
  input  logic [1:0]       in_tbl_rdata,
  output logic             out_tbl_we,
  output logic [TAG_W-1:0] out_tbl_widx,
  output logic [1:0]       out_tbl_wdata,
  output logic             out_pred_ready
`ifdef BP_STATS_EN
  ,
  output logic [31:0]      out_stat_taken,
  output logic [31:0]      out_stat_nottaken
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e             state_q, state_d;
  logic [TAG_W-1:0]   sweep_q, sweep_d;
  logic [TAG_W-1:0]   fifo_tag_q [FIFO_DEPTH];
  logic [TAG_W-1:0]   fifo_tag_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_dir_q, fifo_dir_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               we_q, we_d;
  logic [TAG_W-1:0]   widx_q, widx_d;
  logic [1:0]         wdata_q, wdata_d;
  logic               ready_q, ready_d;

  logic               push, pop, bypass, head_dir;
  logic [TAG_W-1:0]   head_tag;
  logic [1:0]         cur_cnt, new_cnt;

  assign out_rob_full   = (count_q == DEPTH_C);
  assign head_tag       = fifo_tag_q[rd_ptr_q];
  assign head_dir       = fifo_dir_q[rd_ptr_q];
  assign out_tbl_ridx   = head_tag;
  assign out_tbl_we     = we_q;
  assign out_tbl_widx   = widx_q;
  assign out_tbl_wdata  = wdata_q;
  assign out_pred_ready = ready_q;

  always_comb begin
    push    = in_rob_bp_res && rdy && !out_rob_full && !in_pred_clear;
    pop     = rdy && !in_pred_clear && (state_q == ST_RUN) && (count_q != '0);
    // The write registered last cycle has not reached the table yet.
    bypass  = we_q && (widx_q == head_tag);
    cur_cnt = bypass ? wdata_q : in_tbl_rdata;
    if (head_dir) new_cnt = (cur_cnt == 2'b11) ? 2'b11 : cur_cnt + 2'b01;
    else          new_cnt = (cur_cnt == 2'b00) ? 2'b00 : cur_cnt - 2'b01;

    state_d    = state_q;
    sweep_d    = sweep_q;
    fifo_tag_d = fifo_tag_q;
    fifo_dir_d = fifo_dir_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    we_d       = 1'b0;
    widx_d     = widx_q;
    wdata_d    = wdata_q;

    if (rdy) begin
      if (in_pred_clear) begin
        state_d  = ST_INIT;
        sweep_d  = '0;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end else begin
        if (push) begin
          fifo_tag_d[wr_ptr_q] = in_rob_tag;
          fifo_dir_d[wr_ptr_q] = in_rob_jump_res;
          wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        case (state_q)
          ST_INIT: begin
            we_d    = 1'b1;
            widx_d  = sweep_q;
            wdata_d = CNT_INIT;
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == '1) state_d = ST_RUN;
          end
          ST_RUN: begin
            if (pop) begin
              we_d    = 1'b1;
              widx_d  = head_tag;
              wdata_d = new_cnt;
            end
          end
          default: state_d = ST_INIT;
        endcase
      end
    end
    ready_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_INIT;
      sweep_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      widx_q   <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      widx_q   <= widx_d;
      wdata_q  <= wdata_d;
      ready_q  <= ready_d;
    end
  end

  // Entry storage is qualified by count/pointers, so it needs no reset.
  always_ff @(posedge clk) begin
    fifo_tag_q <= fifo_tag_d;
    fifo_dir_q <= fifo_dir_d;
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_t_q, stat_t_d, stat_n_q, stat_n_d;

  always_comb begin
    stat_t_d = stat_t_q;
    stat_n_d = stat_n_q;
    if (rdy && in_pred_clear) begin
      stat_t_d = '0;
      stat_n_d = '0;
    end else if (pop) begin
      if (head_dir) stat_t_d = stat_t_q + 32'd1;
      else          stat_n_d = stat_n_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_t_q <= '0;
      stat_n_q <= '0;
    end else begin
      stat_t_q <= stat_t_d;
      stat_n_q <= stat_n_d;
    end
  end

  assign out_stat_taken    = stat_t_q;
  assign out_stat_nottaken = stat_n_q;
`endif

endmodule

// File: tb/tb_bp_update_scheduler.sv
module tb_bp_update_scheduler;
  localparam int unsigned TAG_W = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned N     = 256;

  logic             clk = 1'b0;
  logic             rst, rdy, clr, bp_res, jump;
  logic [TAG_W-1:0] tag;
  logic             full, we, ready;
  logic [TAG_W-1:0] ridx, widx;
  logic [1:0]       rdata, wdata;
`ifdef BP_STATS_EN
  logic [31:0]      st_t, st_n;
`endif

  bp_update_scheduler #(.TAG_W(TAG_W), .FIFO_DEPTH(DEPTH), .CNT_INIT(2'b01)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .in_pred_clear(clr),
    .in_rob_bp_res(bp_res), .in_rob_tag(tag), .in_rob_jump_res(jump),
    .out_rob_full(full), .out_tbl_ridx(ridx), .in_tbl_rdata(rdata),
    .out_tbl_we(we), .out_tbl_widx(widx), .out_tbl_wdata(wdata),
    .out_pred_ready(ready)
`ifdef BP_STATS_EN
    , .out_stat_taken(st_t), .out_stat_nottaken(st_n)
`endif
  );

  always #5 clk = ~clk;

  // Predictor table: written from the DUT's registered write port.
  logic [1:0]       mem [N];
  logic             poke_en = 1'b0;
  logic [TAG_W-1:0] poke_idx = '0;
  logic [1:0]       poke_val = '0;
  assign rdata = mem[ridx];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) mem[i] <= 2'b00;
    end else begin
      if (we) mem[widx] <= wdata;
      if (poke_en) mem[poke_idx] <= poke_val;
    end
  end

  typedef struct packed {
    logic [TAG_W-1:0] idx;
    logic [1:0]       data;
    logic             upd;
    logic             dir;
  } exp_t;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic             dir;
    logic [1:0]       init;
    logic [1:0]       exp;
  } vec_t;

  exp_t       exp_q[$];
  logic [1:0] pred [N];
  int         n_vec = 0;
  int         n_err = 0;
  int         exp_st_t = 0;
  int         exp_st_n = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [1:0] sat(input logic [1:0] c, input logic d);
    if (d) return (c == 2'b11) ? 2'b11 : c + 2'b01;
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  task automatic load_sweep();
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(exp_t'{idx: TAG_W'(i), data: 2'b01, upd: 1'b0, dir: 1'b0});
      pred[i] = 2'b01;
    end
    exp_st_t = 0;
    exp_st_n = 0;
  endtask

  task automatic expect_upd(input logic [TAG_W-1:0] t, input logic d);
    pred[t] = sat(pred[t], d);
    exp_q.push_back(exp_t'{idx: t, data: pred[t], upd: 1'b1, dir: d});
  endtask

  task automatic poke(input logic [TAG_W-1:0] i, input logic [1:0] v);
    poke_en = 1'b1; poke_idx = i; poke_val = v;
    tick();
    poke_en = 1'b0;
    pred[i] = v;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 600) begin
      tick();
      k++;
    end
    check(name, exp_q.size(), 0);
    tick();
    tick();
  endtask

  task automatic wait_ready(input string name);
    int k = 0;
    while (!ready && k < 400) begin
      tick();
      k++;
    end
    check(name, 32'(ready), 32'd1);
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    load_sweep();
    check("clr_we", 32'(we), 32'd0);
    check("clr_ready", 32'(ready), 32'd0);
    check("clr_full", 32'(full), 32'd0);
  endtask

  task automatic check_stats(input string name);
`ifdef BP_STATS_EN
    check({name, "_taken"}, st_t, exp_st_t);
    check({name, "_nottaken"}, st_n, exp_st_n);
`else
    n_vec += 0;
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t             vt [8];
    logic [TAG_W-1:0] ptag [5];
    logic             pdir [5];
    int               k;

    vt[0] = '{tag: 9,  dir: 1'b0, init: 2'b00, exp: 2'b00};
    vt[1] = '{tag: 9,  dir: 1'b1, init: 2'b00, exp: 2'b01};
    vt[2] = '{tag: 20, dir: 1'b1, init: 2'b01, exp: 2'b10};
    vt[3] = '{tag: 20, dir: 1'b1, init: 2'b11, exp: 2'b11};
    vt[4] = '{tag: 30, dir: 1'b0, init: 2'b11, exp: 2'b10};
    vt[5] = '{tag: 30, dir: 1'b0, init: 2'b10, exp: 2'b01};
    vt[6] = '{tag: 40, dir: 1'b0, init: 2'b01, exp: 2'b00};
    vt[7] = '{tag: 50, dir: 1'b1, init: 2'b10, exp: 2'b11};
    ptag = '{8'd255, 8'd255, 8'd10, 8'd11, 8'd12};
    pdir = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    rst = 1'b0; rdy = 1'b1; clr = 1'b0; bp_res = 1'b0; jump = 1'b0; tag = '0;

    // Write-port scoreboard: every registered write must match the queue head.
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (rst && we) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_write: got idx=%0d data=%b, required no write", widx, wdata);
          end else begin
            e = exp_q.pop_front();
            if (widx !== e.idx || wdata !== e.data) begin
              n_err++;
              $display("FAIL write: got idx=%0d data=%b, required idx=%0d data=%b",
                       widx, wdata, e.idx, e.data);
            end
            if (e.upd) begin
              if (e.dir) exp_st_t++;
              else       exp_st_n++;
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (3) tick();
    check("rst_we", 32'(we), 32'd0);
    check("rst_widx", 32'(widx), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check_stats("rst_stats");

    // Power-on sweep: 256 writes, ready rises with the last one visible
    load_sweep();
    rst = 1'b1;
    for (int c = 1; c <= 256; c++) begin
      tick();
      if (c == 255) check("sweep_ready_lo", 32'(ready), 32'd0);
    end
    check("sweep_ready_hi", 32'(ready), 32'd1);
    wait_drain("sweep_drain");

    // Single-update vectors, including saturation at both ends
    foreach (vt[i]) begin
      poke(vt[i].tag, vt[i].init);
      bp_res = 1'b1; tag = vt[i].tag; jump = vt[i].dir;
      pred[vt[i].tag] = vt[i].exp;
      exp_q.push_back(exp_t'{idx: vt[i].tag, data: vt[i].exp, upd: 1'b1, dir: vt[i].dir});
      tick();
      bp_res = 1'b0;
      wait_drain("vec_drain");
      check("vec_table", 32'(mem[vt[i].tag]), 32'(vt[i].exp));
    end

    // Tag 5 taken x3 back-to-back: bypass and saturation, 2-edge latency
    poke(8'd5, 2'b01);
    bp_res = 1'b1; tag = 8'd5; jump = 1'b1;
    expect_upd(8'd5, 1'b1);
    tick();
    check("lat_idle", 32'(we), 32'd0);
    expect_upd(8'd5, 1'b1);
    tick();
    check("lat_we", 32'(we), 32'd1);
    check("lat_idx", 32'(widx), 32'd5);
    expect_upd(8'd5, 1'b1);
    tick();
    bp_res = 1'b0;
    wait_drain("tag5_drain");
    check("tag5_final", 32'(mem[5]), 32'd3);
    check_stats("run_stats");

    // Fill FIFO during sweep, freeze, then drain right behind the sweep
    poke(8'd255, 2'b11);
    do_clear();
    check_stats("clr_stats");
    for (int i = 0; i < 5; i++) begin
      bp_res = 1'b1; tag = ptag[i]; jump = pdir[i];
      if (i < 4) expect_upd(ptag[i], pdir[i]);
      tick();
      check("fill_full", 32'(full), (i >= 3) ? 32'd1 : 32'd0);
    end
    rdy = 1'b0; tag = 8'd77;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("freeze_we", 32'(we), 32'd0);
      check("freeze_full", 32'(full), 32'd1);
    end
    rdy = 1'b1; bp_res = 1'b0;
    wait_ready("fill_ready");
    check("fill_last_sweep", 32'(widx), 32'd255);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("fill_consec_we", 32'(we), 32'd1);
      if (i == 1) check("fill_full_drop", 32'(full), 32'd0);
    end
    tick();
    check("fill_idle_we", 32'(we), 32'd0);
    wait_drain("fill_drain");

    // Clear at sweep ptr 100 with 2 queued updates
    do_clear();
    bp_res = 1'b1; tag = 8'd3; jump = 1'b1;
    tick();
    tag = 8'd4; jump = 1'b0;
    tick();
    bp_res = 1'b0;
    k = 0;
    while (!(we && widx == 8'd99) && k < 300) begin
      tick();
      k++;
    end
    check("ptr99_seen", 32'(widx), 32'd99);
    do_clear();
    for (int i = 0; i < 2; i++) begin
      bp_res = 1'b1; tag = TAG_W'(6 + i); jump = 1'b1;
      expect_upd(TAG_W'(6 + i), 1'b1);
      tick();
      check("post_clr_full", 32'(full), 32'd0);
    end
    bp_res = 1'b0;
    wait_ready("clr_ready_again");
    wait_drain("clr_drain");

    // rdy=0 for 3 cycles with FIFO non-empty in RUN
    bp_res = 1'b1; tag = 8'd60; jump = 1'b1;
    expect_upd(8'd60, 1'b1);
    tick();
    tag = 8'd61; jump = 1'b0;
    expect_upd(8'd61, 1'b0);
    tick();
    check("hold_we_pre", 32'(we), 32'd1);
    check("hold_idx_pre", 32'(widx), 32'd60);
    rdy = 1'b0; tag = 8'd62;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_we", 32'(we), 32'd0);
    end
    rdy = 1'b1; bp_res = 1'b0;
    tick();
    check("hold_resume_we", 32'(we), 32'd1);
    check("hold_resume_idx", 32'(widx), 32'd61);
    wait_drain("hold_drain");
    check_stats("end_stats");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
